// File: rtl/note_sequencer.sv
// Four-note melody sequencer: plays ones, tens, hund, thou as timed notes with silent gaps.
// Optional build macro SEQ_LOOP_EN: replay the melody continuously until stop or reset.
module note_sequencer #(
    parameter int unsigned NOTE_TICKS = 5_000_000,
    parameter int unsigned GAP_TICKS  = 500_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] tempo_sel,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hund,
    input  logic [3:0] thou,
    output logic [3:0] noteKey,
    output logic       tone_en,
    output logic [3:0] an,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [31:0] GAP_LAST = (GAP_TICKS == 32'd0) ? 32'd0 : 32'(GAP_TICKS - 32'd1);

    state_t      state_q, state_d;
    state_t      adv_state_s;
    logic [1:0]  idx_q, idx_d, adv_idx_s;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] snap_q, snap_d;
    logic [1:0]  tempo_q, tempo_d;
    logic [31:0] note_len_s;
    logic [3:0]  digit_s;

    logic [3:0]  note_key_q, note_key_d;
    logic        tone_en_q, tone_en_d;
    logic [3:0]  an_q, an_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    function automatic logic [3:0] digit_at(input logic [15:0] snap, input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = snap[3:0];
            2'd1:    d = snap[7:4];
            2'd2:    d = snap[11:8];
            2'd3:    d = snap[15:12];
            default: d = 4'd0;
        endcase
        return d;
    endfunction

    assign note_len_s = 32'(NOTE_TICKS) << tempo_q;

    // State register plus registered outputs, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= 32'd0;
            snap_q     <= 16'd0;
            tempo_q    <= 2'd0;
            note_key_q <= 4'd0;
            tone_en_q  <= 1'b0;
            an_q       <= 4'b1111;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            tempo_q    <= tempo_d;
            note_key_q <= note_key_d;
            tone_en_q  <= tone_en_d;
            an_q       <= an_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Next-state logic; stop outranks every counter event outside IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        tempo_d = tempo_q;
        if (idx_q == 2'd3) begin
            adv_state_s = S_FIN;
            adv_idx_s   = idx_q;
        end else begin
            adv_state_s = S_PLAY;
            adv_idx_s   = idx_q + 2'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_PLAY;
                    idx_d   = 2'd0;
                    cnt_d   = 32'd0;
                    snap_d  = {thou, hund, tens, ones};
                    tempo_d = tempo_sel;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = 32'd0;
                end else if (cnt_q == note_len_s - 32'd1) begin
                    cnt_d = 32'd0;
                    if (GAP_TICKS != 32'd0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = adv_state_s;
                        idx_d   = adv_idx_s;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = 32'd0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d   = 32'd0;
                    state_d = adv_state_s;
                    idx_d   = adv_idx_s;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_FIN: begin
                cnt_d = 32'd0;
                idx_d = 2'd0;
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
`ifdef SEQ_LOOP_EN
                    state_d = S_PLAY;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                cnt_d   = 32'd0;
            end
        endcase
    end

    // Output values for the upcoming state, so the registered outputs line up with it.
    always_comb begin
        note_key_d = 4'd0;
        tone_en_d  = 1'b0;
        an_d       = 4'b1111;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        digit_s    = digit_at(snap_d, idx_d);
        case (state_d)
            S_PLAY: begin
                busy_d = 1'b1;
                if (digit_s >= 4'd1 && digit_s <= 4'd9) begin
                    note_key_d = digit_s;
                    tone_en_d  = 1'b1;
                end else begin
                    note_key_d = 4'd0;
                    tone_en_d  = 1'b0;
                end
                case (idx_d)
                    2'd0:    an_d = 4'b1110;
                    2'd1:    an_d = 4'b1101;
                    2'd2:    an_d = 4'b1011;
                    2'd3:    an_d = 4'b0111;
                    default: an_d = 4'b1111;
                endcase
            end
            S_GAP: begin
                busy_d     = 1'b1;
                note_key_d = note_key_q;
            end
            S_FIN: begin
                busy_d     = 1'b1;
                done_d     = 1'b1;
                note_key_d = note_key_q;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign noteKey = note_key_q;
    assign tone_en = tone_en_q;
    assign an      = an_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus queues per-cycle expectations, a monitor checks them.
module tb_note_sequencer;
    localparam int NT = 4;
    localparam int GT = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] tempo_sel = 2'd0;
    logic [3:0] ones = 4'd0, tens = 4'd0, hund = 4'd0, thou = 4'd0;
    logic [3:0] noteKey;
    logic       tone_en;
    logic [3:0] an;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [3:0] key;
        logic       key_chk;
        logic       en;
        logic [3:0] an;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   chk_n = 0;

    note_sequencer #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop), .tempo_sel(tempo_sel),
        .ones(ones), .tens(tens), .hund(hund), .thou(thou),
        .noteKey(noteKey), .tone_en(tone_en), .an(an), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    // Monitor: one expected vector per cycle, sampled mid-cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if ((e.key_chk && noteKey !== e.key) || tone_en !== e.en || an !== e.an ||
                busy !== e.busy || done !== e.done) begin
                fails++;
                $display("FAIL trace[%0d] got key=%h en=%b an=%b busy=%b done=%b, want key=%h(chk=%b) en=%b an=%b busy=%b done=%b",
                         chk_n, noteKey, tone_en, an, busy, done, e.key, e.key_chk, e.en, e.an, e.busy, e.done);
            end
            chk_n++;
        end else if (done !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL stray_done got done=%b, want 0", done);
        end
    end

    task automatic push_e(input logic [3:0] k, input logic kc, input logic en,
                          input logic [3:0] a, input logic b, input logic d);
        exp_t e;
        e = {k, kc, en, a, b, d};
        exp_q.push_back(e);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push_e(4'd0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0);
    endtask

    // One full pass (four notes plus gaps) followed by the done cycle.
    task automatic push_pass(input logic [15:0] dg, input int len);
        logic [3:0] d, k, a;
        logic       v;
        for (int i = 0; i < 4; i++) begin
            d = dg[i*4 +: 4];
            v = (d >= 4'd1) && (d <= 4'd9);
            k = v ? d : 4'd0;
            a = 4'b1111;
            a[i] = 1'b0;
            for (int c = 0; c < len; c++) push_e(k, 1'b1, v, a, 1'b1, 1'b0);
            for (int c = 0; c < GT; c++)  push_e(k, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0);
        end
        push_e(4'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1);
    endtask

    task automatic truncate(input int n);
        exp_t e;
        while (exp_q.size() > n) e = exp_q.pop_back();
    endtask

    task automatic sync_idle();
        while (exp_q.size() != 0) @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, checked while RST_N is still low.
        push_idle(3);
        #27 RST_N = 1'b1;

        // Scenario 1 (+ loop/no-loop tail and stop on the second pass).
        sync_idle();
        {thou, hund, tens, ones} = {4'd3, 4'd0, 4'd5, 4'd1};
        tempo_sel = 2'd0;
        push_pass({thou, hund, tens, ones}, NT);
`ifdef SEQ_LOOP_EN
        for (int c = 0; c < NT; c++) push_e(4'd1, 1'b1, 1'b1, 4'b1110, 1'b1, 1'b0);
`else
        push_idle(NT);
`endif
        push_idle(6);
        pulse_start();
        repeat (28) @(posedge CLK);
        #1 stop = 1'b1;
        @(posedge CLK);
        #1 stop = 1'b0;

        // Scenario 2: slowest tempo, done at cycle 73.
        sync_idle();
        tempo_sel = 2'd2;
        push_pass({thou, hund, tens, ones}, NT << 2);
        push_idle(3);
        pulse_start();
        repeat (73) @(posedge CLK);
        #1 stop = 1'b1;
        @(posedge CLK);
        #1 stop = 1'b0;

        // Scenario 3: stop in the tens note (cycle 8), idle from cycle 9, no done.
        sync_idle();
        tempo_sel = 2'd0;
        push_pass({thou, hund, tens, ones}, NT);
        truncate(8);
        push_idle(25);
        pulse_start();
        repeat (7) @(posedge CLK);
        #1 stop = 1'b1;
        @(posedge CLK);
        #1 stop = 1'b0;

        // Scenario 4: async reset mid-note; no playback afterwards.
        sync_idle();
        push_pass({thou, hund, tens, ones}, NT);
        truncate(2);
        push_idle(25);
        pulse_start();
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b0;
        #5 RST_N = 1'b1;

        // Scenario 5: snapshot holds against input changes and a second start; 4'hA rests.
        sync_idle();
        {thou, hund, tens, ones} = {4'd9, 4'd7, 4'hA, 4'd2};
        push_pass({thou, hund, tens, ones}, NT);
        push_idle(4);
        pulse_start();
        repeat (2) @(posedge CLK);
        #1 {thou, hund, tens, ones} = {4'd1, 4'd1, 4'd1, 4'd1};
        tempo_sel = 2'd3;
        repeat (2) @(posedge CLK);
        #1 pulse_start();

        // Simultaneous start and stop in IDLE: stays idle.
        sync_idle();
        push_idle(5);
        start = 1'b1;
        stop  = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
        stop = 1'b0;

        sync_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Plays the four BCD digits (ones, tens, hund, thou) as a four-note melody, one note after another.
- Each note lasts a programmable time and is followed by a silent gap.
- Drives noteKey/tone_en into the tone generator and an to highlight the digit currently playing.
- Sits between the keypad/BCD entry logic and the tone datapath; the display scan mux does not own noteKey while the sequencer is busy.

Parameters:
- NOTE_TICKS, 5_000_000, base note length in CLK cycles (50 ms at 100 MHz); must be >= 1.
- GAP_TICKS, 500_000, silent gap after each note in CLK cycles; 0 means no gap.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  request playback; sampled only in IDLE.
- stop  input  1  abort playback; level or pulse.
- tempo_sel  input  2  note length = NOTE_TICKS << tempo_sel; sampled at start.
- ones, tens, hund, thou  input  4 each  melody digits, played in the order ones, tens, hund, thou.
- noteKey  output  4  note code to the tone generator.
- tone_en  output  1  tone generator enable.
- an  output  4  active-low digit highlight.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  one-cycle pulse when the melody completes normally.

Behaviour:
- Reset (async, RST_N=0):
  - State = IDLE.
  - noteKey = 0, tone_en = 0, an = 4'b1111, busy = 0, done = 0.
  - Index, tick counter and snapshot registers cleared.
  - Outputs take these values immediately, not at the next edge.
- All outputs are registered.
- Snapshot: the four digits and tempo_sel are latched on the start edge. Later input changes are ignored until the next start.
- States:
  - IDLE: start=1 and stop=0 -> latch snapshot, index = 0, go to PLAY. The first note's outputs are valid on the next cycle (latency 1).
  - PLAY: lasts exactly L = NOTE_TICKS << tempo_sel cycles (counter 0..L-1, 32-bit, no overflow for the defaults).
    - Valid note (digit 1..9): noteKey = digit, tone_en = 1.
    - Rest (digit 0 or 10..15): noteKey = 0, tone_en = 0.
    - an = index 0: 1110, index 1: 1101, index 2: 1011, index 3: 0111.
    - Exit to GAP, or skip GAP when GAP_TICKS = 0.
  - GAP: tone_en = 0, noteKey held, an = 1111, for exactly GAP_TICKS cycles.
  - End of note: if index < 3, increment index and go to PLAY. If index = 3, go to DONE.
  - DONE: one cycle; done = 1, tone_en = 0, an = 1111, busy = 1. Then IDLE with busy = 0.
- stop:
  - In any non-IDLE state, stop has priority over every counter event.
  - Next cycle: IDLE, tone_en = 0, noteKey = 0, an = 1111, busy = 0, no done pulse.
- Simultaneous start and stop in IDLE: stop wins; the block stays in IDLE.
- start while busy: ignored, no restart.
- Timing: total cycles from the start sample to the done pulse = 1 + 4*(L + GAP_TICKS).

Optional Feature:
- Macro: SEQ_LOOP_EN.
- Defined:
  - After index 3 completes, the sequencer pulses done for one cycle, then re-enters PLAY at index 0 on the following cycle.
  - It uses the same snapshot and keeps busy = 1.
  - It repeats until stop or reset; stop behaves exactly as above.
- Undefined: single pass only, as described above. No loop logic is synthesized.

Test Plan:
All scenarios use NOTE_TICKS=4, GAP_TICKS=2 unless stated.
1. thou,hund,tens,ones = 3,0,5,1; tempo_sel=0; start pulse at cycle 0.
   - Cycles 1-4: noteKey=1, tone_en=1, an=1110. Cycles 5-6: tone_en=0, an=1111.
   - tens=5 with an=1101. hund rests: tone_en=0 for 4 cycles with an=1011. thou=3 with an=0111.
   - done pulse at cycle 25; busy low at cycle 26.
2. tempo_sel=2, same digits: each PLAY lasts 16 cycles; done at cycle 73.
3. stop asserted during the tens note: next cycle tone_en=0, noteKey=0, an=1111, busy=0; done never pulses.
4. RST_N low mid-PLAY, between clock edges: outputs go to reset values immediately. After RST_N returns high, no playback occurs until a new start.
5. Digit input changes and a second start pulse during playback: both ignored; the original snapshot plays. A digit of 10 (4'hA) plays as a rest.
6. With SEQ_LOOP_EN defined:
   - done pulses at cycle 25, then index 0 replays from cycle 26.
   - stop during the second pass returns to IDLE with no further done pulse.
   - Without the macro: IDLE after cycle 25.
